uart_mmio_bridge: RTL and testbench
===================================

UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 we  input  1  bus write strobe, one cycle per access.
REQ-005 re  input  1  bus read strobe, one cycle per access.
REQ-006 addr  input  4  byte offset: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CTRL.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  read data.
REQ-009 Tx_Data  output  8  byte to UART TX data register.
REQ-010 tx_data_en  output  1  load strobe for UART TX data register.
REQ-011 tx_send  output  1  send request value.
REQ-012 tx_send_en  output  1  load strobe for UART send register.
REQ-013 tx_send_w  input  1  UART send flag; high while a frame is in flight, cleared by UART at stop bit.
REQ-014 Rx_Data_w  input  8  received byte.
REQ-015 in_save_data_bits_w  input  1  RX-ready flag from UART.
REQ-016 parity_error  input  1  UART parity error.
REQ-017 rx_data_clf  output  1  one-cycle clear pulse for RX-ready flag.

Function
REQ-018 rdata is combinational from addr, valid while re=1, 0 when re=0: RXDATA={24'b0,Rx_Data_w}; STATUS bit0 rx_ready, bit1 parity_sticky, bit2 fifo_full, bit3 fifo_empty, bit4 tx_busy, bit5 overflow_sticky, bits[11:8] fifo count; TXDATA and CTRL read 0.
REQ-019 we to TXDATA pushes wdata[7:0] into the FIFO.
REQ-020 A push while full and with no pop in the same cycle is dropped and sets overflow_sticky.
REQ-021 A push while full with a pop in the same cycle is accepted and the count stays at FIFO_DEPTH.
REQ-022 The TX FSM runs IDLE -> LOAD -> SEND -> WAIT_START -> WAIT_DONE -> IDLE.
REQ-023 IDLE moves to LOAD when the FIFO is not empty.
REQ-024 LOAD asserts tx_data_en with Tx_Data = FIFO head for one cycle and pops the head.
REQ-025 SEND asserts tx_send_en=1 and tx_send=1 for one cycle.
REQ-026 WAIT_START holds until tx_send_w=1.
REQ-027 WAIT_DONE holds until tx_send_w=0, then returns to IDLE.
REQ-028 Minimum gap from a push into an empty FIFO to tx_data_en is one cycle.
REQ-029 Back-to-back bytes are never loaded while tx_send_w=1.
REQ-030 tx_busy = (FSM != IDLE) or fifo not empty.
REQ-031 rx_data_clf pulses for one cycle on re to RXDATA or on we to CTRL with wdata[0]=1.
REQ-032 Simultaneous RXDATA read and CTRL write produce a single pulse.
REQ-033 parity_sticky sets in any cycle where parity_error=1 and in_save_data_bits_w=1, and clears on CTRL write with wdata[1]=1; a same-cycle set wins.
REQ-034 overflow_sticky clears on CTRL write with wdata[2]=1; a same-cycle set wins.
REQ-035 tx_send is 0 and tx_data_en/tx_send_en are 0 outside LOAD/SEND.

Reset
REQ-036 While rst=0: FIFO empty, pointers 0, FSM IDLE, stickies 0, and every output 0 (rdata, Tx_Data, tx_data_en, tx_send, tx_send_en, rx_data_clf).
REQ-037 Reset mid-frame abandons the byte and discards FIFO contents.
REQ-038 After reset release, no pulse is issued until a new push.

Configuration
REQ-039 With UART_BRIDGE_IRQ_EN defined: add output irq (1 bit) = (CTRL bit3 rx_ie & rx_ready) | (CTRL bit4 tx_ie & fifo_empty & FSM IDLE), registered, reset 0; rx_ie/tx_ie are stored CTRL bits, readable at CTRL bits[4:3].
REQ-040 Without UART_BRIDGE_IRQ_EN: no irq port; CTRL bits 3-4 are ignored and read 0.

Structure
REQ-041 UART_pkg holds the tx_ctrl_state_t enum, register offset constants, and STATUS/CTRL bit index constants.
REQ-042 The FIFO is sub-module uart_tx_fifo (push/pop/full/empty/count, parameter FIFO_DEPTH).
REQ-043 The FSM, register decode and stickies live in the top module.

Verification
REQ-044 Write 0x55 to TXDATA with tx_send_w modelled 10 cycles high -> tx_data_en with Tx_Data=0x55 one cycle later, tx_send_en next cycle, FSM IDLE after tx_send_w falls.
REQ-045 Write 0x01..0x05 back-to-back with DEPTH=4 -> bytes 0x01..0x04 sent in order, 0x05 dropped or accepted per REQ-021 timing, STATUS bit5 matches.
REQ-046 in_save_data_bits_w=1, Rx_Data_w=0xA3, read RXDATA -> rdata=0x000000A3 and a one-cycle rx_data_clf pulse.
REQ-047 parity_error=1 with ready, then CTRL write 0x2 in the same cycle as a new error -> STATUS bit1 stays 1.
REQ-048 Assert rst=0 in WAIT_DONE with 3 queued bytes -> all outputs 0, STATUS fifo_empty=1, no load after release.
REQ-049 With UART_BRIDGE_IRQ_EN, CTRL=0x8 and RX ready -> irq=1 next cycle; irq=0 after the RXDATA read.

Source files
------------

// File: rtl/UART_pkg.sv
// Shared types and register map for the UART MMIO bridge: TX controller states,
// bus offsets and STATUS/CTRL bit positions.
package UART_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_START,
        S_WAIT_DONE
    } tx_ctrl_state_t;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int unsigned STS_RX_READY  = 0;
    localparam int unsigned STS_PARITY    = 1;
    localparam int unsigned STS_FULL      = 2;
    localparam int unsigned STS_EMPTY     = 3;
    localparam int unsigned STS_BUSY      = 4;
    localparam int unsigned STS_OVERFLOW  = 5;
    localparam int unsigned STS_COUNT_LSB = 8;

    localparam int unsigned CTRL_RX_CLR  = 0;
    localparam int unsigned CTRL_PAR_CLR = 1;
    localparam int unsigned CTRL_OVF_CLR = 2;
    localparam int unsigned CTRL_RX_IE   = 3;
    localparam int unsigned CTRL_TX_IE   = 4;

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// Simple single-cycle register bus between a bus master and the UART bridge.
interface uart_mmio_bridge_if;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, re, addr, wdata, input rdata);
    modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the TX path; FIFO_DEPTH must be a power of two so pointers wrap naturally.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [7:0]                   din_i,
    output logic [7:0]                   dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // A pop frees the slot in the same cycle, so a push against a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/uart_mmio_bridge.sv
// Bus-to-UART bridge: register decode, TX FIFO drain FSM and RX/parity/overflow status.
// Defining UART_BRIDGE_IRQ_EN adds a registered irq output driven by CTRL rx_ie/tx_ie.
module uart_mmio_bridge
    import UART_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_mmio_bridge_if.slave bus,
    output logic [7:0]        Tx_Data,
    output logic              tx_data_en,
    output logic              tx_send,
    output logic              tx_send_en,
    input  logic              tx_send_w,
    input  logic [7:0]        Rx_Data_w,
    input  logic              in_save_data_bits_w,
    input  logic              parity_error,
    output logic              rx_data_clf
`ifdef UART_BRIDGE_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_ctrl_state_t state_q, state_d;
    logic           parity_q, parity_d;
    logic           ovf_q, ovf_d;
    logic           wr_tx, wr_ctrl, rd_rx;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_head;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status;
    logic [31:0]    ctrl_rd;
    logic           unused_wdata;

    assign wr_tx        = bus.we && (bus.addr == OFF_TXDATA);
    assign wr_ctrl      = bus.we && (bus.addr == OFF_CTRL);
    assign rd_rx        = bus.re && (bus.addr == OFF_RXDATA);
    assign fifo_pop     = (state_q == S_LOAD);
    assign unused_wdata = ^bus.wdata;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_tx),
        .pop_i   (fifo_pop),
        .din_i   (bus.wdata[7:0]),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        Tx_Data    = '0;
        tx_data_en = 1'b0;
        tx_send    = 1'b0;
        tx_send_en = 1'b0;
        case (state_q)
            S_IDLE:       if (!fifo_empty) state_d = S_LOAD;
            S_LOAD: begin
                tx_data_en = 1'b1;
                Tx_Data    = fifo_head;
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_send    = 1'b1;
                tx_send_en = 1'b1;
                state_d    = S_WAIT_START;
            end
            S_WAIT_START: if (tx_send_w)  state_d = S_WAIT_DONE;
            S_WAIT_DONE:  if (!tx_send_w) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Set terms are OR-ed last so a same-cycle event beats a software clear.
    always_comb begin
        parity_d = (parity_q && !(wr_ctrl && bus.wdata[CTRL_PAR_CLR]))
                 || (parity_error && in_save_data_bits_w);
        ovf_d    = (ovf_q && !(wr_ctrl && bus.wdata[CTRL_OVF_CLR]))
                 || (wr_tx && fifo_full && !fifo_pop);
    end

    assign rx_data_clf = rst && (rd_rx || (wr_ctrl && bus.wdata[CTRL_RX_CLR]));

    always_comb begin
        status                        = '0;
        status[STS_RX_READY]          = in_save_data_bits_w;
        status[STS_PARITY]            = parity_q;
        status[STS_FULL]              = fifo_full;
        status[STS_EMPTY]             = fifo_empty;
        status[STS_BUSY]              = (state_q != S_IDLE) || !fifo_empty;
        status[STS_OVERFLOW]          = ovf_q;
        status[STS_COUNT_LSB +: 4]    = 4'(fifo_count);
    end

`ifdef UART_BRIDGE_IRQ_EN
    logic rx_ie_q, tx_ie_q, irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ie_q <= 1'b0;
            tx_ie_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_ie_q <= bus.wdata[CTRL_RX_IE];
                tx_ie_q <= bus.wdata[CTRL_TX_IE];
            end
            irq_q <= (rx_ie_q && in_save_data_bits_w)
                  || (tx_ie_q && fifo_empty && (state_q == S_IDLE));
        end
    end

    assign irq = irq_q;

    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[CTRL_RX_IE] = rx_ie_q;
        ctrl_rd[CTRL_TX_IE] = tx_ie_q;
    end
`else
    assign ctrl_rd = '0;
`endif

    always_comb begin
        bus.rdata = '0;
        if (rst && bus.re) begin
            case (bus.addr)
                OFF_RXDATA: bus.rdata = {24'b0, Rx_Data_w};
                OFF_STATUS: bus.rdata = status;
                OFF_CTRL:   bus.rdata = ctrl_rd;
                default:    bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: queue-based reference model checked every cycle plus directed
// scenarios with literal expectations; irq checks are compiled in with UART_BRIDGE_IRQ_EN.
module tb_uart_mmio_bridge;
    localparam int unsigned D = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  Tx_Data;
    logic        tx_data_en, tx_send, tx_send_en, tx_send_w;
    logic [7:0]  Rx_Data_w;
    logic        in_save_data_bits_w, parity_error, rx_data_clf;
`ifdef UART_BRIDGE_IRQ_EN
    logic        irq;
`endif

    uart_mmio_bridge_if bus ();

    uart_mmio_bridge #(.FIFO_DEPTH(D)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .Tx_Data             (Tx_Data),
        .tx_data_en          (tx_data_en),
        .tx_send             (tx_send),
        .tx_send_en          (tx_send_en),
        .tx_send_w           (tx_send_w),
        .Rx_Data_w           (Rx_Data_w),
        .in_save_data_bits_w (in_save_data_bits_w),
        .parity_error        (parity_error),
        .rx_data_clf         (rx_data_clf)
`ifdef UART_BRIDGE_IRQ_EN
        ,
        .irq                 (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: pending bytes plus where the sender is in its handshake.
    logic [7:0] mq[$];
    bit  m_load, m_send, m_fly, m_high, m_par, m_ovf, m_rxie, m_txie, m_irq;
    logic [7:0] loads[$];
    int  load_cyc[$];
    int  send_cyc[$];
    int  clf_count = 0;
    int  uart_hold = 10;

    initial begin : compare
        bit          idle, rd_rx, wctrl, wtx, n_irq, n_ovf, n_par;
        int          n;
        logic [31:0] st, exp_rd;
        logic [7:0]  exp_tx;
        bit          exp_clf;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                {m_load, m_send, m_fly, m_high, m_par, m_ovf, m_rxie, m_txie, m_irq} = '0;
                chk("rst_rdata", bus.rdata, 32'h0);
                chk("rst_outputs", {20'b0, Tx_Data, tx_data_en, tx_send, tx_send_en, rx_data_clf}, 32'h0);
`ifdef UART_BRIDGE_IRQ_EN
                chk("rst_irq", {31'b0, irq}, 32'h0);
`endif
            end else begin
                idle  = !m_load && !m_send && !m_fly;
                n     = mq.size();
                rd_rx = bus.re && bus.addr == 4'h4;
                wctrl = bus.we && bus.addr == 4'hC;
                wtx   = bus.we && bus.addr == 4'h0;
                st = 32'h0;
                st[0] = in_save_data_bits_w;
                st[1] = m_par;
                st[2] = (n == D);
                st[3] = (n == 0);
                st[4] = !idle || n != 0;
                st[5] = m_ovf;
                st[11:8] = 4'(n);
                exp_rd = 32'h0;
                if (bus.re) begin
                    if (bus.addr == 4'h4) exp_rd = {24'b0, Rx_Data_w};
                    else if (bus.addr == 4'h8) exp_rd = st;
`ifdef UART_BRIDGE_IRQ_EN
                    else if (bus.addr == 4'hC) exp_rd = {27'b0, m_txie, m_rxie, 3'b0};
`endif
                end
                exp_tx  = (m_load && n > 0) ? mq[0] : 8'h00;
                exp_clf = rd_rx || (wctrl && bus.wdata[0]);
                chk("rdata", bus.rdata, exp_rd);
                chk("outputs", {20'b0, Tx_Data, tx_data_en, tx_send, tx_send_en, rx_data_clf},
                    {20'b0, exp_tx, m_load, m_send, m_send, exp_clf});
`ifdef UART_BRIDGE_IRQ_EN
                chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
                if (tx_data_en) begin loads.push_back(Tx_Data); load_cyc.push_back(cyc); end
                if (tx_send_en) send_cyc.push_back(cyc);
                if (rx_data_clf) clf_count++;

                n_irq = (m_rxie && in_save_data_bits_w) || (m_txie && n == 0 && idle);
                n_par = (m_par && !(wctrl && bus.wdata[1])) || (parity_error && in_save_data_bits_w);
                n_ovf = m_ovf && !(wctrl && bus.wdata[2]);
                if (m_load && n > 0) void'(mq.pop_front());
                if (wtx) begin
                    if (mq.size() < D) mq.push_back(bus.wdata[7:0]);
                    else n_ovf = 1'b1;
                end
                if (wctrl) begin m_rxie = bus.wdata[3]; m_txie = bus.wdata[4]; end
                m_irq = n_irq; m_par = n_par; m_ovf = n_ovf;
                if (m_load) begin m_load = 0; m_send = 1; end
                else if (m_send) begin m_send = 0; m_fly = 1; m_high = 0; end
                else if (m_fly) begin
                    if (!m_high) begin if (tx_send_w) m_high = 1; end
                    else if (!tx_send_w) m_fly = 0;
                end
                else if (n > 0) m_load = 1;
            end
        end
    end

    // UART transmitter stand-in: raises its busy flag the cycle after a send request.
    initial begin : uart
        int cnt;
        bit pend;
        tx_send_w = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            pend = rst && tx_send_en;
            @(posedge clk);
            #1;
            if (!rst) begin cnt = 0; tx_send_w = 1'b0; end
            else if (pend) begin tx_send_w = 1'b1; cnt = uart_hold; end
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_send_w = 1'b0;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        bus.re = 1'b1; bus.addr = a;
        @(negedge clk); v = bus.rdata;
        @(posedge clk); #1;
        bus.re = 1'b0;
    endtask

    initial begin : main
        logic [31:0] v;
        int wc, base, c0;
        bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
        rst = 0; Rx_Data_w = 0; in_save_data_bits_w = 0; parity_error = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        tick(1);
        rd(4'h8, v); chk("status_after_reset", v, 32'h0000_0008);

        // Single byte with a 10-cycle frame.
        uart_hold = 10;
        wc = cyc;
        wr(4'h0, 32'h55);
        tick(20);
        chk("single_load_count", loads.size(), 1);
        chk("single_byte", (loads.size() > 0) ? {24'b0, loads[0]} : 32'hFFFF_FFFF, 32'h55);
        chk("single_load_gap", (load_cyc.size() > 0) ? load_cyc[0] - wc : -1, 2);
        chk("single_send_gap", (send_cyc.size() > 0 && load_cyc.size() > 0) ? send_cyc[0] - load_cyc[0] : -1, 1);
        rd(4'h8, v); chk("single_idle_status", v, 32'h0000_0008);

        // Burst of six: 0x01..0x05 fit (one pops mid-burst), 0x06 hits a full FIFO.
        uart_hold = 3;
        base = loads.size();
        for (int b = 1; b <= 6; b++) wr(4'h0, 32'(b));
        rd(4'h8, v); chk("burst_full_status", v, 32'h0000_0434);
        tick(60);
        chk("burst_load_count", loads.size() - base, 5);
        for (int i = 0; i < 5; i++)
            chk("burst_order", (loads.size() > base + i) ? {24'b0, loads[base + i]} : 32'hFFFF_FFFF, 32'(i + 1));
        rd(4'h8, v); chk("burst_drained_status", v, 32'h0000_0028);
        wr(4'hC, 32'h4);
        rd(4'h8, v); chk("ovf_cleared_status", v, 32'h0000_0008);

        // RX byte read and clear pulses.
        in_save_data_bits_w = 1; Rx_Data_w = 8'hA3;
        tick(1);
        c0 = clf_count;
        rd(4'h4, v); chk("rxdata", v, 32'h0000_00A3);
        in_save_data_bits_w = 0;
        tick(1);
        chk("clf_on_read", clf_count - c0, 1);
        wr(4'hC, 32'h1);
        tick(1);
        chk("clf_on_ctrl", clf_count - c0, 2);

        // Parity sticky: set, then clear racing a new error, then a plain clear.
        parity_error = 1; in_save_data_bits_w = 1;
        tick(1);
        parity_error = 0; in_save_data_bits_w = 0;
        rd(4'h8, v); chk("parity_set", v, 32'h0000_000A);
        parity_error = 1; in_save_data_bits_w = 1;
        wr(4'hC, 32'h2);
        parity_error = 0; in_save_data_bits_w = 0;
        rd(4'h8, v); chk("parity_set_wins", v, 32'h0000_000A);
        wr(4'hC, 32'h2);
        rd(4'h8, v); chk("parity_cleared", v, 32'h0000_0008);

        // Reset while waiting for the frame to finish with three bytes still queued.
        uart_hold = 10;
        base = loads.size();
        for (int b = 0; b < 4; b++) wr(4'h0, 32'hA0 + 32'(b));
        tick(2);
        rst = 0;
        rd(4'h8, v); chk("status_in_reset", v, 32'h0);
        tick(1);
        rst = 1;
        rd(4'h8, v); chk("status_after_midframe_reset", v, 32'h0000_0008);
        tick(20);
        chk("loads_across_reset", loads.size() - base, 1);

`ifdef UART_BRIDGE_IRQ_EN
        wr(4'hC, 32'h8);
        rd(4'hC, v); chk("ctrl_ie_readback", v, 32'h0000_0008);
        in_save_data_bits_w = 1; Rx_Data_w = 8'h3C;
        tick(2);
        chk("irq_rx_ready", {31'b0, irq}, 32'h1);
        rd(4'h4, v);
        in_save_data_bits_w = 0;
        tick(2);
        chk("irq_after_read", {31'b0, irq}, 32'h0);
        wr(4'hC, 32'h0);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
